aes_round_ctrl: RTL and testbench

- Round sequencer for the AES-128 encryption datapath.
- Sits between the host-side interface FSM and the round datapath. The interface FSM shifts in the message and key, then pulses start.
- This block drives the initial AddRoundKey, rounds 1..NUM_ROUNDS, the key-expansion steps and Rcon, then holds result_valid until the interface FSM acknowledges the read-out.

---
 rtl/aes_round_ctrl.sv | 132 +++++++++++++
 tb/tb_aes_round_ctrl.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/aes_round_ctrl.sv
// Round sequencer for the AES-128 encryption datapath: drives the initial AddRoundKey,
// the rounds, key-expansion steps and Rcon, then holds the result until it is acknowledged.
module aes_round_ctrl #(
    parameter int unsigned NUM_ROUNDS   = 10,
    parameter int unsigned ROUND_CYCLES = 1
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start,
    input  logic       key_valid,
    input  logic       abort,
    input  logic       rd_ack,
    output logic       busy,
    output logic       init_ark,
    output logic       load_state,
    output logic       key_step,
    output logic       skip_mix,
    output logic [3:0] round,
    output logic [7:0] rcon,
    output logic       result_valid
);

    typedef enum logic [2:0] {
        StIdle,
        StInit,
        StRound,
        StFinal,
        StDone
    } state_e;

    localparam logic [3:0] LastRound = 4'(NUM_ROUNDS);
    localparam logic [3:0] LastCc    = 4'(ROUND_CYCLES - 1);
    localparam logic [7:0] RconInit  = 8'h01;

    state_e     state_q, state_d;
    logic [3:0] round_q, round_d;
    logic [3:0] cc_q, cc_d;
    logic [7:0] rcon_q, rcon_d;
    logic       last_cycle;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1B : 8'h00);
    endfunction

    assign last_cycle = (cc_q == LastCc);

    always_comb begin
        state_d = state_q;
        round_d = round_q;
        cc_d    = cc_q;
        rcon_d  = rcon_q;
        unique case (state_q)
            StIdle: begin
                if (start && key_valid) begin
                    state_d = StInit;
                    round_d = 4'd0;
                    cc_d    = 4'd0;
                    rcon_d  = RconInit;
                end
            end
            StInit: begin
                state_d = StRound;
                round_d = 4'd1;
                cc_d    = 4'd0;
                rcon_d  = xtime(rcon_q);
            end
            StRound: begin
                if (last_cycle) begin
                    cc_d    = 4'd0;
                    round_d = round_q + 4'd1;
                    rcon_d  = xtime(rcon_q);
                    if (round_q + 4'd1 == LastRound) begin
                        state_d = StFinal;
                    end
                end else begin
                    cc_d = cc_q + 4'd1;
                end
            end
            StFinal: begin
                if (last_cycle) begin
                    state_d = StDone;
                    cc_d    = 4'd0;
                end else begin
                    cc_d = cc_q + 4'd1;
                end
            end
            StDone: begin
                if (rd_ack) begin
                    state_d = StIdle;
                    round_d = 4'd0;
                    rcon_d  = RconInit;
                end
            end
            default: state_d = StIdle;
        endcase
        // Abort overrides every transition, including a start taken in the same cycle.
        if (abort) begin
            state_d = StIdle;
            round_d = 4'd0;
            cc_d    = 4'd0;
            rcon_d  = RconInit;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
            round_q <= 4'd0;
            cc_q    <= 4'd0;
            rcon_q  <= RconInit;
        end else begin
            state_q <= state_d;
            round_q <= round_d;
            cc_q    <= cc_d;
            rcon_q  <= rcon_d;
        end
    end

    // Only the two write enables see abort directly, so an aborted cycle never commits.
    always_comb begin
        busy         = (state_q == StInit) || (state_q == StRound) || (state_q == StFinal);
        init_ark     = (state_q == StInit);
        skip_mix     = (state_q == StFinal);
        result_valid = (state_q == StDone);
        load_state   = !abort && ((state_q == StInit) ||
                                  (((state_q == StRound) || (state_q == StFinal)) && last_cycle));
        key_step     = !abort && ((state_q == StInit) || ((state_q == StRound) && last_cycle));
        round        = round_q;
        rcon         = rcon_q;
    end

endmodule

// File: tb/tb_aes_round_ctrl.sv
// Randomized bench for aes_round_ctrl: two instances (1 and 3 cycles per round) compared
// every cycle against a latency-formula model of the round schedule.
module tb_aes_round_ctrl;

    localparam int NR = 10;

    logic clk = 1'b0;
    logic reset, start, key_valid, abort, rd_ack;

    logic       busy_a, init_a, load_a, key_a, skip_a, rv_a;
    logic [3:0] round_a;
    logic [7:0] rcon_a;
    logic       busy_b, init_b, load_b, key_b, skip_b, rv_b;
    logic [3:0] round_b;
    logic [7:0] rcon_b;

    int n_checks = 0;
    int n_errors = 0;
    int cyc = 0;
    int rv_at_a = -1;
    int rv_at_b = -1;

    // Model: per instance, 0 idle, 1 active (rel = cycles since start), 2 done.
    int m_state[2];
    int m_rel[2];
    logic [7:0] rcon_seq[0:15];

    always #5 clk = ~clk;

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_CYCLES(1)) dut_a (
        .clk(clk), .reset(reset), .start(start), .key_valid(key_valid), .abort(abort),
        .rd_ack(rd_ack), .busy(busy_a), .init_ark(init_a), .load_state(load_a),
        .key_step(key_a), .skip_mix(skip_a), .round(round_a), .rcon(rcon_a),
        .result_valid(rv_a)
    );

    aes_round_ctrl #(.NUM_ROUNDS(NR), .ROUND_CYCLES(3)) dut_b (
        .clk(clk), .reset(reset), .start(start), .key_valid(key_valid), .abort(abort),
        .rd_ack(rd_ack), .busy(busy_b), .init_ark(init_b), .load_state(load_b),
        .key_step(key_b), .skip_mix(skip_b), .round(round_b), .rcon(rcon_b),
        .result_valid(rv_b)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        n_checks++;
        if (obs !== exp_v) begin
            n_errors++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", tag, cyc, obs, exp_v);
        end
    endtask

    task automatic check_inst(input int i, input string nm, input logic busy, input logic ia,
                              input logic ld, input logic ks, input logic sm, input logic rv,
                              input logic [3:0] rnd, input logic [7:0] rc_byte);
        int rc, rel, r;
        logic last;
        logic e_busy, e_ia, e_ld, e_ks, e_sm, e_rv, chk_rcon;
        logic [3:0] e_round;
        logic [7:0] e_rcon;
        rc = (i == 0) ? 1 : 3;
        {e_busy, e_ia, e_ld, e_ks, e_sm, e_rv, chk_rcon} = '0;
        e_round = 4'd0;
        e_rcon  = 8'h01;
        if (m_state[i] == 1) begin
            rel = m_rel[i];
            e_busy = 1'b1;
            if (rel == 1) begin
                {e_ia, e_ld, e_ks, chk_rcon} = 4'b1111;
                e_rcon = rcon_seq[0];
            end else begin
                r = (rel - 2) / rc + 1;
                last = ((rel - 2) % rc) == rc - 1;
                e_round = 4'(r);
                e_ld = last;
                if (r < NR) begin
                    e_ks = last;
                    chk_rcon = 1'b1;
                    e_rcon = rcon_seq[r];
                end else begin
                    e_sm = 1'b1;
                end
            end
        end else if (m_state[i] == 2) begin
            e_rv = 1'b1;
            e_round = 4'(NR);
        end
        if (abort) begin
            e_ld = 1'b0;
            e_ks = 1'b0;
        end
        chk({nm, ".busy"}, busy, e_busy);
        chk({nm, ".init_ark"}, ia, e_ia);
        chk({nm, ".load_state"}, ld, e_ld);
        chk({nm, ".key_step"}, ks, e_ks);
        chk({nm, ".skip_mix"}, sm, e_sm);
        chk({nm, ".result_valid"}, rv, e_rv);
        chk({nm, ".round"}, rnd, e_round);
        if (chk_rcon) chk({nm, ".rcon"}, rc_byte, e_rcon);
    endtask

    task automatic model_update();
        for (int i = 0; i < 2; i++) begin
            int rc;
            rc = (i == 0) ? 1 : 3;
            if (abort) begin
                m_state[i] = 0;
            end else if (m_state[i] == 0) begin
                if (start && key_valid) begin
                    m_state[i] = 1;
                    m_rel[i] = 1;
                end
            end else if (m_state[i] == 1) begin
                m_rel[i]++;
                if (m_rel[i] == 2 + NR * rc) m_state[i] = 2;
            end else if (rd_ack) begin
                m_state[i] = 0;
            end
        end
    endtask

    // Sample between edges, then advance the model on the rising edge.
    task automatic step();
        @(negedge clk);
        check_inst(0, "rc1", busy_a, init_a, load_a, key_a, skip_a, rv_a, round_a, rcon_a);
        check_inst(1, "rc3", busy_b, init_b, load_b, key_b, skip_b, rv_b, round_b, rcon_b);
        if (rv_a && rv_at_a < 0) rv_at_a = cyc;
        if (rv_b && rv_at_b < 0) rv_at_b = cyc;
        @(posedge clk);
        model_update();
        cyc++;
        #1;
    endtask

    task automatic check_reset_vals();
        chk("rst.busy", {busy_a, busy_b}, 2'b00);
        chk("rst.init_ark", {init_a, init_b}, 2'b00);
        chk("rst.load_state", {load_a, load_b}, 2'b00);
        chk("rst.key_step", {key_a, key_b}, 2'b00);
        chk("rst.skip_mix", {skip_a, skip_b}, 2'b00);
        chk("rst.result_valid", {rv_a, rv_b}, 2'b00);
        chk("rst.round", {round_a, round_b}, 8'h00);
        chk("rst.rcon", {rcon_a, rcon_b}, 16'h0101);
        m_state[0] = 0;
        m_state[1] = 0;
    endtask

    initial begin
        int c0;
        rcon_seq[0] = 8'h01;
        for (int k = 1; k < 16; k++) begin
            rcon_seq[k] = {rcon_seq[k-1][6:0], 1'b0} ^ (rcon_seq[k-1][7] ? 8'h1B : 8'h00);
        end
        reset = 1'b1; start = 1'b0; key_valid = 1'b1; abort = 1'b0; rd_ack = 1'b0;
        #12;
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        step();

        // start without key, start with abort, rd_ack while idle
        start = 1'b1; key_valid = 1'b0; step();
        start = 1'b0; key_valid = 1'b1; step();
        start = 1'b1; abort = 1'b1; step();
        start = 1'b0; abort = 1'b0; rd_ack = 1'b1; step();
        rd_ack = 1'b0; step();

        // full run with stray starts during busy and done
        c0 = cyc; rv_at_a = -1; rv_at_b = -1;
        start = 1'b1; step();
        for (int k = 1; k < 40; k++) begin
            start  = (k == 5) || (k == 13) || (k == 33);
            rd_ack = (k == 35);
            step();
        end
        start = 1'b0; rd_ack = 1'b0;
        chk("latency.rc1", rv_at_a - c0, 12);
        chk("latency.rc3", rv_at_b - c0, 32);

        // abort in round 5, then a fresh start
        start = 1'b1; step();
        start = 1'b0;
        for (int k = 1; k < 6; k++) step();
        abort = 1'b1; step();
        abort = 1'b0;
        for (int k = 0; k < 3; k++) step();
        start = 1'b1; step();
        start = 1'b0;
        for (int k = 0; k < 4; k++) step();

        // asynchronous reset between edges, mid-round
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals();
        @(posedge clk);
        #1;
        reset = 1'b0;
        c0 = cyc; rv_at_a = -1;
        start = 1'b1; step();
        start = 1'b0;
        for (int k = 1; k < 40; k++) begin
            rd_ack = (k == 36);
            step();
        end
        rd_ack = 1'b0;
        chk("latency.after_reset", rv_at_a - c0, 12);

        for (int k = 0; k < 3000; k++) begin
            key_valid = ($urandom_range(0, 7) != 0);
            start     = ($urandom_range(0, 3) == 0);
            abort     = ($urandom_range(0, 59) == 0);
            rd_ack    = ($urandom_range(0, 3) == 0);
            step();
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
